// File: rtl/sram_loader.sv
// sram_loader: synthesizable SRAM preload engine. Accepts a valid/ready word
// stream and writes it into the SRAM from a programmable base address, with an
// optional readback pass that compares a modular checksum of what was written
// against a checksum of what reads back.
module sram_loader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 7,
  parameter bit VERIFY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              verify,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_datain,
  output logic              sram_write_pulse,
  output logic              sram_read_pulse,
  output logic              sram_addr_ready,
  input  logic [DATA_W-1:0] sram_dataout,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_WPULSE, S_WGAP, S_RPULSE, S_RCAP, S_CHECK, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     reads_q;
  logic [ADDR_W:0]     reads_next;
  logic                verify_q;
  logic [DATA_W-1:0]   wsum_q;
  logic [DATA_W-1:0]   rsum_q;
  logic                last_write;

  assign reads_next = reads_q + 1'b1;
  // words_done has already been bumped in WPULSE when WGAP evaluates this.
  assign last_write = (words_done == count_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (start) state_d = (word_count == '0) ? S_DONE : S_ACCEPT;
        S_ACCEPT: if (in_valid) state_d = S_WPULSE;
        S_WPULSE: state_d = S_WGAP;
        S_WGAP: begin
          if (!last_write)   state_d = S_ACCEPT;
          else if (verify_q) state_d = S_RPULSE;
          else               state_d = S_DONE;
        end
        S_RPULSE: state_d = S_RCAP;
        S_RCAP:   state_d = (reads_next < count_q) ? S_RPULSE : S_CHECK;
        S_CHECK:  state_d = S_DONE;
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Output decode; abort suppresses strobes, handshake and done in its cycle.
  always_comb begin
    in_ready         = 1'b0;
    sram_write_pulse = 1'b0;
    sram_read_pulse  = 1'b0;
    done             = 1'b0;
    busy             = (state_q != S_IDLE);
    if (!abort) begin
      case (state_q)
        S_ACCEPT: in_ready         = 1'b1;
        S_WPULSE: sram_write_pulse = 1'b1;
        S_RPULSE: sram_read_pulse  = 1'b1;
        S_DONE:   done             = 1'b1;
        default:  ;
      endcase
    end
  end

  assign sram_addr_ready = sram_write_pulse | sram_read_pulse;

  // Datapath: job parameters latched at start, write data, address, counters, sums.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments make every register see pre-edge values, independent of statement order.
    if (!rst_n) begin
      base_q      <= '0;
      count_q     <= '0;
      verify_q    <= 1'b0;
      reads_q     <= '0;
      wsum_q      <= '0;
      rsum_q      <= '0;
      sram_addr   <= '0;
      sram_datain <= '0;
      words_done  <= '0;
      error       <= 1'b0;
    end else if (!abort) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q     <= base_addr;
            count_q    <= word_count;
            verify_q   <= verify & VERIFY_EN;
            words_done <= '0;
            error      <= 1'b0;
            wsum_q     <= '0;
            sram_addr  <= base_addr;
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            sram_datain <= in_data;
            wsum_q      <= wsum_q + in_data;
          end
        end
        S_WPULSE: words_done <= words_done + 1'b1;
        S_WGAP: begin
          if (last_write && verify_q) begin
            sram_addr <= base_q;
            rsum_q    <= '0;
            reads_q   <= '0;
          end else begin
            sram_addr <= sram_addr + 1'b1;
          end
        end
        S_RCAP: begin
          rsum_q    <= rsum_q + sram_dataout;
          sram_addr <= sram_addr + 1'b1;
          reads_q   <= reads_next;
        end
        S_CHECK: error <= (rsum_q != wsum_q);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_loader.sv
// tb_sram_loader: table-driven and randomized checks of sram_loader against a
// transaction-level model (expected write/read lists, latencies, final state)
// derived from the loader's timing rules, with a behavioural SRAM attached.
module tb_sram_loader;

  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          verify = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, wp, rp, ar, busy, done, error;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_datain, sram_dataout;
  logic [AW:0]   words_done;

  sram_loader #(.DATA_W(DW), .ADDR_W(AW), .VERIFY_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .verify(verify), .abort(abort),
    .base_addr(base_addr), .word_count(word_count), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .sram_addr(sram_addr),
    .sram_datain(sram_datain), .sram_write_pulse(wp), .sram_read_pulse(rp),
    .sram_addr_ready(ar), .sram_dataout(sram_dataout), .busy(busy),
    .done(done), .error(error), .words_done(words_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: synchronous write, registered read, optional bit flip on one address.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q = '0;
  bit            corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  always @(posedge clk) begin
    if (wp) mem[sram_addr] <= sram_datain;
    if (rp) rd_q <= mem[sram_addr] ^ ((corrupt_en && sram_addr == corrupt_addr) ? 32'h4 : 32'h0);
  end
  assign sram_dataout = rd_q;

  typedef struct {
    int            c;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ev_t;

  typedef struct {
    logic [AW-1:0] base;
    int            n;
    bit            vfy;
    int            gap;
    int            corrupt;
    int            exp_lat;
    bit            exp_err;
  } vec_t;

  logic [DW-1:0] stim [$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] outs();
    return 96'({in_ready, wp, rp, ar, busy, done, error, sram_addr, sram_datain, words_done});
  endfunction

  function automatic int model_latency(input int n, input bit vfy, input int gap);
    return 1 + n * (3 + gap) + ((vfy && n > 0) ? 2 * n + 1 : 0);
  endfunction

  task automatic fill_random(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back($urandom);
  endtask

  // One complete load: drive start and the stream, log SRAM traffic, compare with the model.
  task automatic run_load(input string tag, input logic [AW-1:0] base, input int n, input bit vfy,
                          input int gap, input int corrupt, input int exp_lat, input bit exp_err);
    ev_t wr [$];
    ev_t rd [$];
    int  s;
    int  wi = 0;
    int  stall = 0;
    int  rdy = 0;
    int  bad_ar = 0;
    int  done_cyc = -1;
    int  img_bad = 0;
    int  n_rd;
    corrupt_en   = (corrupt >= 0);
    corrupt_addr = AW'(int'(base) + corrupt);
    @(negedge clk);
    start = 1'b1; base_addr = base; word_count = (AW+1)'(n); verify = vfy; in_valid = 1'b0;
    s = cyc;
    @(negedge clk);
    start = 1'b0; base_addr = AW'($urandom); word_count = (AW+1)'($urandom); verify = 1'($urandom);
    check({tag, " cleared at start"}, 96'({error, words_done}), 96'(0));
    for (int t = 0; t < exp_lat + 40 && done_cyc < 0; t++) begin
      if (in_ready && wi < n) begin
        if (stall < gap) begin
          in_valid = 1'b0;
          stall++;
        end else begin
          in_valid = 1'b1;
          in_data  = stim[wi];
        end
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_ready) rdy++;
      if (in_ready && in_valid) begin
        wi++;
        stall = 0;
      end
      if (wp) wr.push_back('{cyc, sram_addr, sram_datain});
      if (rp) rd.push_back('{cyc, sram_addr, '0});
      if (ar !== (wp | rp) || (wp && rp)) bad_ar++;
      if (done) done_cyc = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({tag, " done latency"}, 96'(done_cyc - s), 96'(exp_lat));
    check({tag, " idle after done"}, 96'({busy, done, wp, rp, in_ready}), 96'(0));
    check({tag, " words_done"}, 96'(words_done), 96'(n));
    check({tag, " error"}, 96'(error), 96'(exp_err));
    check({tag, " write count"}, 96'(wr.size()), 96'(n));
    for (int i = 0; i < wr.size() && i < n; i++)
      check($sformatf("%s write %0d {cycle,addr,data}", tag, i),
            96'({32'(wr[i].c - s), wr[i].a, wr[i].d}),
            96'({32'(2 + gap + i * (gap + 3)), AW'(int'(base) + i), stim[i]}));
    n_rd = (vfy && n > 0) ? n : 0;
    check({tag, " read count"}, 96'(rd.size()), 96'(n_rd));
    for (int i = 0; i < rd.size() && i < n_rd; i++)
      check($sformatf("%s read %0d {cycle,addr}", tag, i),
            96'({32'(rd[i].c - s), rd[i].a}),
            96'({32'(n * (3 + gap) + 1 + 2 * i), AW'(int'(base) + i)}));
    check({tag, " in_ready cycles"}, 96'(rdy), 96'(n * (gap + 1)));
    check({tag, " addr_ready vs strobes"}, 96'(bad_ar), 96'(0));
    for (int i = 0; i < n; i++)
      if (mem[AW'(int'(base) + i)] !== stim[i]) img_bad++;
    check({tag, " sram image"}, 96'(img_bad), 96'(0));
    repeat (2) @(negedge clk);
    check({tag, " error sticky"}, 96'(error), 96'(exp_err));
    corrupt_en = 1'b0;
  endtask

  initial begin
    vec_t tbl [8];
    int   n, gap, cor;
    bit   vfy;
    int   found;
    int   late_done;

    tbl[0] = '{7'h00,   4, 1'b0, 0, -1,  13, 1'b0};
    tbl[1] = '{7'h7E,   4, 1'b0, 2, -1,  21, 1'b0};
    tbl[2] = '{7'h10,   3, 1'b1, 0, -1,  17, 1'b0};
    tbl[3] = '{7'h10,   3, 1'b1, 0,  2,  17, 1'b1};
    tbl[4] = '{7'h33,   0, 1'b0, 0, -1,   1, 1'b0};
    tbl[5] = '{7'h05, 128, 1'b0, 0, -1, 385, 1'b0};
    tbl[6] = '{7'h40, 128, 1'b1, 1,  5, 770, 1'b1};
    tbl[7] = '{7'h03,   2, 1'b1, 1, -1,  14, 1'b0};

    repeat (3) @(negedge clk);
    check("reset outputs", outs(), 96'(0));
    rst_n = 1'b1;

    // Table-driven loads.
    for (int v = 0; v < 8; v++) begin
      if (v == 0) stim = '{32'h11, 32'h22, 32'h33, 32'h44};
      else fill_random(tbl[v].n);
      run_load($sformatf("tbl%0d", v), tbl[v].base, tbl[v].n, tbl[v].vfy, tbl[v].gap,
               tbl[v].corrupt, tbl[v].exp_lat, tbl[v].exp_err);
    end

    // Start while busy is ignored; abort in WPULSE kills the strobe and returns to IDLE.
    @(negedge clk);
    start = 1'b1; base_addr = 7'h20; word_count = 8'd4; verify = 1'b0;
    in_valid = 1'b1; in_data = 32'hA5A5_0001;
    @(negedge clk);                                   // ACCEPT, first word taken
    start = 1'b0;
    @(negedge clk);                                   // WPULSE
    @(negedge clk);                                   // WGAP
    @(negedge clk);                                   // ACCEPT, stray start
    start = 1'b1; base_addr = 7'h55; word_count = 8'd0; in_data = 32'hA5A5_0002;
    @(negedge clk);                                   // WPULSE, abort here
    start = 1'b0; in_valid = 1'b0; abort = 1'b1;
    #1;
    check("abort strobes", 96'({wp, ar, done}), 96'(0));
    check("start ignored {addr,data}", 96'({sram_addr, sram_datain}), 96'({7'h21, 32'hA5A5_0002}));
    @(negedge clk);
    abort = 1'b0;
    check("abort -> idle", 96'({busy, done, words_done}), 96'({1'b0, 1'b0, 8'd1}));
    late_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    check("no done after abort", 96'(late_done), 96'(0));

    // Reset asserted during RPULSE clears every output immediately.
    fill_random(3);
    @(negedge clk);
    start = 1'b1; base_addr = 7'h10; word_count = 8'd3; verify = 1'b1;
    in_valid = 1'b1; in_data = stim[0];
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int t = 0; t < 40 && found == 0; t++) begin
      if (rp) found = 1;
      else @(negedge clk);
    end
    check("reached RPULSE", 96'(found), 96'(1));
    rst_n = 1'b0;
    #1;
    check("reset mid-read outputs", outs(), 96'(0));
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stim = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_load("post-reset", 7'h00, 4, 1'b0, 0, -1, 13, 1'b0);

    // Randomized loads against the model.
    for (int r = 0; r < 24; r++) begin
      n   = (r % 8 == 7) ? DEPTH : int'($urandom_range(0, 12));
      vfy = 1'($urandom_range(0, 1));
      gap = int'($urandom_range(0, 3));
      cor = (n > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      fill_random(n);
      run_load($sformatf("rnd%0d", r), AW'($urandom), n, vfy, gap, cor,
               model_latency(n, vfy, gap), vfy && cor >= 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
